// File: rtl/ppu_pkg.sv
// Shared types and helpers for the pixel processing unit: mode encoding,
// default geometry, and pixel field pack/unpack.
package ppu_pkg;

  typedef enum logic [2:0] {
    PPU_PASS  = 3'd0,
    PPU_XOR   = 3'd1,
    PPU_BARS  = 3'd2,
    PPU_CHECK = 3'd3,
    PPU_INV   = 3'd4
  } ppu_mode_e;

  localparam int PPU_CH_W     = 2;
  localparam int PPU_H_TOTAL  = 800;
  localparam int PPU_V_TOTAL  = 525;
  localparam int PPU_MAX_CH_W = 8;
  localparam int PPU_PW       = 4 * PPU_MAX_CH_W;

  typedef logic [PPU_MAX_CH_W-1:0] chan_t;

  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
    chan_t pad;
  } pixel_t;

  // Channels are held at maximum width; only the low ch_w bits of each are packed.
  function automatic logic [PPU_PW-1:0] pix_pack(input pixel_t p, input int ch_w);
    logic [PPU_PW-1:0] m;
    m = (PPU_PW'(1) << ch_w) - PPU_PW'(1);
    return ((PPU_PW'(p.r) & m) << (3 * ch_w)) | ((PPU_PW'(p.g) & m) << (2 * ch_w)) |
           ((PPU_PW'(p.b) & m) << ch_w) | (PPU_PW'(p.pad) & m);
  endfunction

  function automatic pixel_t pix_unpack(input logic [PPU_PW-1:0] d, input int ch_w);
    logic [PPU_PW-1:0] m;
    pixel_t u;
    m     = (PPU_PW'(1) << ch_w) - PPU_PW'(1);
    u.r   = chan_t'((d >> (3 * ch_w)) & m);
    u.g   = chan_t'((d >> (2 * ch_w)) & m);
    u.b   = chan_t'((d >> ch_w) & m);
    u.pad = chan_t'(d & m);
    return u;
  endfunction

  function automatic logic pat_hit(input logic [10:0] v);
    logic [10:0] r;
    r = (v % 11'd7) | (v % 11'd9);
    return r <= 11'd1;
  endfunction

endpackage

// File: rtl/ppu_stream_if.sv
// Pixel stream bus: input valid/ready into the unit and registered output
// valid/ready toward the VGA stage.
interface ppu_stream_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/ppu_fifo.sv
// Small synchronous FIFO with first-word-fall-through read; a push while full
// is accepted only when a pop happens in the same cycle.
module ppu_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              wr_en;
  logic              rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/ppu_stream.sv
// Pixel processing unit: FIFO-buffered input, per-pixel screen position, and a
// registered output that passes, inverts or generates pixels by mode.
// Build option: define PPU_FRAME_ANIM_EN to animate the xor pattern.
module ppu_stream
  import ppu_pkg::*;
#(
  parameter int CH_W       = PPU_CH_W,
  parameter int DATA_W     = 4 * CH_W,
  parameter int H_TOTAL    = PPU_H_TOTAL,
  parameter int V_TOTAL    = PPU_V_TOTAL,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_DIV  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic [2:0] mode,
  ppu_stream_if.slave bus
);
  localparam int SX_W = $clog2(H_TOTAL);
  localparam int SY_W = $clog2(V_TOTAL);

  logic [SX_W-1:0]   sx_q, sx_d;
  logic [SY_W-1:0]   sy_q, sy_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [10:0]       anim_q;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty, push, pop, load, uses_fifo;
  ppu_mode_e         mode_e;

  ppu_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (bus.in_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign mode_e        = ppu_mode_e'(mode);
  assign uses_fifo     = (mode_e == PPU_PASS) || (mode_e == PPU_INV);
  assign load          = (!out_valid_q || bus.out_ready) && (!uses_fifo || !fifo_empty);
  assign pop           = load && uses_fifo;
  assign push          = bus.in_valid && !fifo_full;
  assign bus.in_ready  = !fifo_full;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

`ifdef PPU_FRAME_ANIM_EN
  localparam int DIV_W = $clog2(FRAME_DIV + 1);
  logic [DIV_W-1:0] div_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      anim_q <= '0;
    end else if (div_q == DIV_W'(FRAME_DIV - 1)) begin
      div_q  <= '0;
      anim_q <= anim_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end
`else
  logic unused_frame_div;
  assign unused_frame_div = (FRAME_DIV != 0);
  assign anim_q           = '0;
`endif

  // Sync overrides the advance, so a coincident load still uses the old position.
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (sync) begin
      sx_d = '0;
      sy_d = '0;
    end else if (load) begin
      if (sx_q == SX_W'(H_TOTAL - 1)) begin
        sx_d = '0;
        sy_d = (sy_q == SY_W'(V_TOTAL - 1)) ? '0 : sy_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
      end
    end
  end

  logic [10:0] sx_w, sy_w, xa, ya;
  pixel_t      in_px, px;

  assign sx_w = 11'(sx_q);
  assign sy_w = 11'(sy_q);
  assign xa   = sx_w + anim_q;
  assign ya   = sy_w + anim_q;

  always_comb begin
    in_px = pix_unpack(PPU_PW'(fifo_dout), CH_W);
    px    = '0;
    case (mode_e)
      PPU_PASS: px = in_px;
      PPU_XOR: begin
        px.r = {PPU_MAX_CH_W{pat_hit(ya ^ xa)}};
        px.g = ~px.r;
        px.b = {PPU_MAX_CH_W{pat_hit((ya + 11'd1) ^ (xa + 11'd1))}};
      end
      PPU_BARS: begin
        px.r = {PPU_MAX_CH_W{sx_w[8]}};
        px.g = {PPU_MAX_CH_W{sx_w[7]}};
        px.b = {PPU_MAX_CH_W{sx_w[6]}};
      end
      PPU_CHECK: begin
        if (sx_w[4] ^ sy_w[4]) begin
          px.r = '1;
          px.g = '1;
          px.b = '1;
        end
      end
      PPU_INV: begin
        px     = in_px;
        px.r   = ~in_px.r;
        px.g   = ~in_px.g;
        px.b   = ~in_px.b;
      end
      default: px = '0;
    endcase
    out_data_d  = DATA_W'(pix_pack(px, CH_W));
    out_valid_d = load ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) out_data_q <= out_data_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end
endmodule

// File: tb/tb_ppu_stream.sv
// Directed bench for ppu_stream: a table of pattern vectors plus hand-written
// sequences for latency, backpressure, sync and reset.
module tb_ppu_stream;
  localparam int H = 800;
  localparam int V = 18;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync;
  logic [2:0] mode;

  ppu_stream_if #(.DATA_W(8)) bus ();

  ppu_stream #(
    .CH_W(2), .H_TOTAL(H), .V_TOTAL(V), .FIFO_DEPTH(4), .FRAME_DIV(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sync(sync),
    .mode(mode),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    int         skip;
    logic       push;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[20];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int idx);
    mode          = 3'd5;
    sync          = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = vecs[idx].push;
    bus.in_data   = vecs[idx].din;
    step();
    sync         = 1'b0;
    bus.in_valid = 1'b0;
    repeat (vecs[idx].skip) step();
    mode = vecs[idx].mode;
    step();
    $display("vec %0d: mode %0d skip %0d -> valid %0b data %h (want %h)",
             idx, vecs[idx].mode, vecs[idx].skip, bus.out_valid, bus.out_data, vecs[idx].exp);
    check($sformatf("vec%0d", idx), {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, vecs[idx].exp});
    mode = 3'd5;
  endtask

  initial begin
    int   sent;
    int   recv;
    logic acc;
    logic take;
    logic [7:0] got;

    vecs[0]  = '{3'd1, 0,             1'b0, 8'h00, 8'hCC};
    vecs[1]  = '{3'd1, 1,             1'b0, 8'h00, 8'hC0};
    vecs[2]  = '{3'd1, 2,             1'b0, 8'h00, 8'h30};
    vecs[3]  = '{3'd1, 61,            1'b0, 8'h00, 8'h3C};
    vecs[4]  = '{3'd3, 0,             1'b0, 8'h00, 8'h00};
    vecs[5]  = '{3'd3, 16,            1'b0, 8'h00, 8'hFC};
    vecs[6]  = '{3'd3, 16 * H,        1'b0, 8'h00, 8'hFC};
    vecs[7]  = '{3'd3, H * V + 16,    1'b0, 8'h00, 8'hFC};
    vecs[8]  = '{3'd2, H * V,         1'b0, 8'h00, 8'h00};
    vecs[9]  = '{3'd2, 64,            1'b0, 8'h00, 8'h0C};
    vecs[10] = '{3'd2, 128,           1'b0, 8'h00, 8'h30};
    vecs[11] = '{3'd2, 256,           1'b0, 8'h00, 8'hC0};
    vecs[12] = '{3'd2, 320,           1'b0, 8'h00, 8'hCC};
    vecs[13] = '{3'd2, 448,           1'b0, 8'h00, 8'hFC};
    vecs[14] = '{3'd4, 0,             1'b1, 8'h12, 8'hEE};
    vecs[15] = '{3'd0, 0,             1'b1, 8'h5A, 8'h5A};
    vecs[16] = '{3'd7, 0,             1'b1, 8'h33, 8'h00};
    vecs[17] = '{3'd0, 0,             1'b0, 8'h00, 8'h33};
    vecs[18] = '{3'd6, 5,             1'b1, 8'hA5, 8'h00};
    vecs[19] = '{3'd4, 0,             1'b0, 8'h00, 8'h59};

    // Reset state
    rst = 1'b1; sync = 1'b0; mode = 3'd0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;
    repeat (3) step();
    check("idle_valid", {31'd0, bus.out_valid}, 32'd0);

    // Passthrough latency: push at edge N, loaded at edge N+1
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    step();
    bus.in_valid = 1'b0;
    check("lat_edge_n", {31'd0, bus.out_valid}, 32'd0);
    step();
    check("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lat_data", {24'd0, bus.out_data}, 32'h5A);
    step();
    check("lat_drain", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure
    bus.out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h10 + 8'(sent);
      acc = bus.in_ready;
      step();
      if (acc) begin
        exp_q.push_back(8'h10 + 8'(sent));
        sent++;
      end
    end
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("bp_accepted", sent, 5);
    check("bp_head", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'h10});
    mode = 3'd2;
    repeat (2) step();
    check("bp_hold", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'h10});
    mode = 3'd0;
    bus.out_ready = 1'b1;
    recv = 0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      bus.in_valid = (sent < 6);
      bus.in_data  = 8'h10 + 8'(sent);
      acc  = bus.in_valid && bus.in_ready;
      take = bus.out_valid && bus.out_ready;
      got  = bus.out_data;
      step();
      if (acc) begin
        exp_q.push_back(8'h10 + 8'(sent));
        sent++;
      end
      if (take) begin
        check($sformatf("bp_order%0d", recv), {24'd0, got}, {24'd0, exp_q.pop_front()});
        $display("bp: received %h", got);
        recv++;
      end
    end
    bus.in_valid = 1'b0;
    check("bp_count", recv, 6);
    step();
    check("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // Pattern table
    for (int i = 0; i < 20; i++) apply_vec(i);

    // sync mid-line, with a mode change while stalled
    mode = 3'd5; sync = 1'b1; bus.out_ready = 1'b1;
    step();
    sync = 1'b0; mode = 3'd3;
    repeat (20) step();
    check("sync_x19", {24'd0, bus.out_data}, 32'hFC);
    bus.out_ready = 1'b0; sync = 1'b1; mode = 3'd2;
    step();
    sync = 1'b0;
    check("stall_mode_hold", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'hFC});
    mode = 3'd3; bus.out_ready = 1'b1;
    step();
    check("sync_mid", {24'd0, bus.out_data}, 32'h00);
    repeat (16) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_coinc_pre", {24'd0, bus.out_data}, 32'hFC);
    step();
    check("sync_coinc_post", {24'd0, bus.out_data}, 32'h00);

    // Asynchronous reset mid-transfer discards FIFO contents
    mode = 3'd0; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    repeat (3) step();
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_data", {24'd0, bus.out_data}, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    rst = 1'b0; bus.out_ready = 1'b1;
    repeat (3) step();
    check("arst_flushed", {31'd0, bus.out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
